// File: rtl/game_pkg.sv
// Shared constants for the game: button bit positions and default debounce timing.
package game_pkg;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned NUM_BTNS  = 4;

    // 10 ms at 100 MHz; the counter width must hold DEBOUNCE_CYCLES-1.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned CNT_W_DEF           = 20;

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-flop synchroniser, counter debouncer and registered press/release pulses.
module debounce_bit
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_next,
    output logic press,
    output logic released
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             qualify;

    assign qualify = (s2 != level) && (cnt == CNT_LAST);

    // Exposes the level this edge will register so the top can align the combo pulse.
    assign level_next = qualify ? s2 : level;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            press    <= 1'b0;
            released <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (!qualify) begin
                cnt <= cnt + 1'b1;
            end else begin
                level    <= s2;
                cnt      <= '0;
                press    <= s2;
                released <= ~s2;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw push-buttons: per-bit debounce plus any-press and all-four combo detection.
module button_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                any_press,
    output logic                combo_pulse
);

    logic [NUM_BTNS-1:0] next_level;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .raw       (btn_raw[i]),
            .level     (btn_level[i]),
            .level_next(next_level[i]),
            .press     (btn_press[i]),
            .released  (btn_release[i])
        );
    end

    assign any_press = |btn_press;

    // Current btn_level acts as the previous-cycle all-held state, so the pulse fires once per entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_pulse <= 1'b0;
        end else begin
            combo_pulse <= (&next_level) & ~(&btn_level);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       any_press;
    logic       combo_pulse;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press),
        .combo_pulse(combo_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rel, input logic cmb);
        check({tag, " level"},   {28'd0, btn_level},   {28'd0, lvl});
        check({tag, " press"},   {28'd0, btn_press},   {28'd0, prs});
        check({tag, " release"}, {28'd0, btn_release}, {28'd0, rel});
        check({tag, " any"},     {31'd0, any_press},   {31'd0, |prs});
        check({tag, " combo"},   {31'd0, combo_pulse}, {31'd0, cmb});
    endtask

    initial begin
        // 1: reset with all buttons held
        rst     = 1'b1;
        btn_raw = 4'b1111;
        tick(1);
        check_all("rst_e1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("rst_e2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        tick(1);
        check_all("post_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        btn_raw = 4'b0000;
        tick(10);
        check_all("quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 2: bit0 press latency
        btn_raw[0] = 1'b1;
        tick(5);
        check_all("up_e4", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("up_e5", 4'b0001, 4'b0001, 4'b0000, 1'b0);
        tick(1);
        check_all("up_e6", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // 3: 3-cycle glitch on bit2 is rejected
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            check_all("glitch", 4'b0001, 4'b0000, 4'b0000, 1'b0);
            tick(1);
        end

        // 4: bit1 release timing
        btn_raw[1] = 1'b1;
        tick(10);
        check_all("dn_held", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        btn_raw[1] = 1'b0;
        tick(5);
        check_all("dn_rel_e4", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("dn_rel_e5", 4'b0001, 4'b0000, 4'b0010, 1'b0);
        tick(1);
        check_all("dn_rel_e6", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // 5: combo on all four, no retrigger while held, re-arm after a release
        btn_raw = 4'b0000;
        tick(10);
        check_all("all_low", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        btn_raw = 4'b1111;
        tick(5);
        check_all("combo_e4", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("combo_e5", 4'b1111, 4'b1111, 4'b0000, 1'b1);
        for (int unsigned k = 0; k < 20; k++) begin
            tick(1);
            check_all("combo_hold", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        btn_raw[3] = 1'b0;
        tick(6);
        check("rt_dropped", {28'd0, btn_level}, 32'h7);
        check("rt_no_combo", {31'd0, combo_pulse}, 32'h0);
        btn_raw[3] = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            tick(1);
            check("rearm_wait", {31'd0, combo_pulse}, 32'h0);
        end
        tick(1);
        check_all("combo2", 4'b1111, 4'b1000, 4'b0000, 1'b1);
        tick(1);
        check("combo2_end", {31'd0, combo_pulse}, 32'h0);

        // 6: reset in the middle of a release count
        btn_raw = 4'b0000;
        tick(10);
        btn_raw[0] = 1'b1;
        tick(8);
        check("b0_up", {28'd0, btn_level}, 32'h1);
        btn_raw[0] = 1'b0;
        tick(4);
        check("b0_counting", {28'd0, btn_level}, 32'h1);
        rst = 1'b1;
        tick(1);
        check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        rst = 1'b0;
        for (int unsigned k = 0; k < 6; k++) begin
            tick(1);
            check_all("after_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        btn_raw[0] = 1'b1;
        tick(5);
        check_all("fresh_e4", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("fresh_e5", 4'b0001, 4'b0001, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
